axi_wr_sched: RTL and testbench
===============================

// Module: axi_wr_sched
// PURPOSE
//   Shares one AXI4 write master among NUM_REQ single-beat write requesters (DMA/ring writers).
//   Round-robin arbitration; each granted beat is captured into a holding register and issued as one AW+W pair.
//   Outstanding B responses are tracked and routed back to the originating requester via AWID.
//   Sits between the per-queue stream writers and the memory-side AXI interconnect.
// PARAMETERS
//   NUM_REQ          4    number of requesters (2..8)
//   DATA_WIDTH       512  AXI/requester data width, bits
//   KEEP_WIDTH       64   DATA_WIDTH/8, strobe width
//   ADDR_WIDTH       34   AXI address width
//   ID_WIDTH         6    AXI ID width; must be >= clog2(NUM_REQ)
//   MAX_OUTSTANDING  8    max issued writes awaiting B (1..255)
// PORTS
//   clk            in   1                     clock; all logic on rising edge
//   rst_n          in   1                     synchronous, active-low reset
//   req_valid      in   NUM_REQ               per-requester write request
//   req_ready      out  NUM_REQ               one-hot accept pulse
//   req_addr       in   NUM_REQ*ADDR_WIDTH    flattened byte addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data       in   NUM_REQ*DATA_WIDTH    flattened write data
//   req_strb       in   NUM_REQ*KEEP_WIDTH    flattened byte strobes
//   done_valid     out  NUM_REQ               one-cycle completion pulse per requester
//   done_resp      out  2                     BRESP accompanying done_valid
//   m_axi_aw*      out  id/addr/len/size/burst/lock/cache/prot/valid; awready in
//   m_axi_w*       out  wdata/wstrb/wlast/wvalid; wready in
//   m_axi_b*       in   bid(ID_WIDTH)/bresp(2)/bvalid; bready out
//   outstanding    out  8                     current count of writes awaiting B
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, req_ready=0, done_valid=0, awvalid=wvalid=0, bready=0,
//     outstanding=0, rr_ptr=0, done_resp=0. Responses for writes in flight at reset are discarded.
//   Constants: awlen=0, awsize=clog2(KEEP_WIDTH), awburst=INCR, awlock=0, awcache=0, awprot=0, wlast=wvalid.
//   awaddr = captured addr with low clog2(KEEP_WIDTH) bits forced to 0; awid = zero-extended grant index.
//   FSM IDLE: eligible = req_valid & (outstanding < MAX_OUTSTANDING). Grant the first set bit of req_valid searching
//     from rr_ptr upward with wrap. On grant: req_ready[g]=1 for exactly this cycle; capture addr/data/strb/g;
//     outstanding+1; rr_ptr <= (g+1) mod NUM_REQ; next state ISSUE. No grant -> stay in IDLE, req_ready=0.
//   FSM ISSUE: awvalid and wvalid both asserted on entry (same cycle). Each drops the cycle after its own handshake;
//     AW and W complete in either order or together. Both complete -> IDLE. Payload stable while valid.
//   Throughput: at most one beat per 2 cycles; req_valid->req_ready combinational in IDLE; req_ready->awvalid 1 cycle.
//   B channel: bready=1 whenever out of reset. On bvalid&bready: done_valid[bid[clog2(NUM_REQ)-1:0]]=1 next cycle,
//     done_resp=bresp, outstanding-1. Simultaneous grant and B in one cycle: outstanding unchanged.
//   Full: outstanding==MAX_OUTSTANDING blocks all grants until a B arrives; ISSUE in progress still completes.
//   Out-of-range bid (index >= NUM_REQ): counter still decrements, no done pulse.
//   Requester dropping req_valid before req_ready is legal; request is simply not granted.
// TESTING
//   T1 single: req_valid=0001, addr=0x1000_0040, awready=wready=1 -> req_ready[0] 1 cycle; next cycle AW addr 0x10000040,
//      awid=0, wstrb/wdata match; bvalid bid=0 bresp=0 -> done_valid=0001, outstanding 1->0.
//   T2 round robin: req_valid=1111 held, all ready -> grant order 0,1,2,3,0; each req_ready 2 cycles apart.
//   T3 split handshake: awready=1 at cycle 1, wready held 0 until cycle 4 -> awvalid drops cycle 2, wvalid stays
//      high to cycle 4, next grant no earlier than cycle 5.
//   T4 full: bvalid held 0, requests pending -> exactly 8 grants, then req_ready=0; one B -> exactly one more grant.
//   T5 simultaneous grant + B at outstanding=3 -> stays 3; bresp=2'b10 on bid=2 -> done_valid=0100, done_resp=2'b10.
//   T6 reset mid-ISSUE: rst_n low 1 cycle during awvalid -> awvalid/wvalid/bready=0, outstanding=0, rr_ptr=0 next cycle.

Source files
------------

// File: rtl/axi_wr_sched.sv
// Round-robin scheduler sharing one AXI4 write master among NUM_REQ single-beat writers.
// Each grant issues one AW+W pair; B responses are routed back to the requester by AWID.
module axi_wr_sched #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 34,
  parameter int ID_WIDTH        = 6,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]    i_req_strb,
  output logic [NUM_REQ-1:0]               o_done_valid,
  output logic [1:0]                       o_done_resp,
  output logic [ID_WIDTH-1:0]              o_m_axi_awid,
  output logic [ADDR_WIDTH-1:0]            o_m_axi_awaddr,
  output logic [7:0]                       o_m_axi_awlen,
  output logic [2:0]                       o_m_axi_awsize,
  output logic [1:0]                       o_m_axi_awburst,
  output logic                             o_m_axi_awlock,
  output logic [3:0]                       o_m_axi_awcache,
  output logic [2:0]                       o_m_axi_awprot,
  output logic                             o_m_axi_awvalid,
  input  logic                             i_m_axi_awready,
  output logic [DATA_WIDTH-1:0]            o_m_axi_wdata,
  output logic [KEEP_WIDTH-1:0]            o_m_axi_wstrb,
  output logic                             o_m_axi_wlast,
  output logic                             o_m_axi_wvalid,
  input  logic                             i_m_axi_wready,
  input  logic [ID_WIDTH-1:0]              i_m_axi_bid,
  input  logic [1:0]                       i_m_axi_bresp,
  input  logic                             i_m_axi_bvalid,
  output logic                             o_m_axi_bready,
  output logic [7:0]                       o_outstanding
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW   = IDXW + 1;
  localparam int SZ   = $clog2(KEEP_WIDTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                  r_state;
  logic [IDXW-1:0]         r_rr_ptr;
  logic [7:0]              r_cnt;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic [NUM_REQ-1:0]      r_done_valid;
  logic [1:0]              r_done_resp;
  logic [ID_WIDTH-1:0]     r_awid;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [KEEP_WIDTH-1:0]   r_wstrb;

  logic                    w_found;
  logic [IDXW-1:0]         w_gidx;
  logic [SW-1:0]           w_sum;
  logic [SW-1:0]           w_next_ptr;
  logic                    w_grant;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [KEEP_WIDTH-1:0]   w_sel_strb;
  logic                    w_b_hs;
  logic                    w_dec;
  logic [IDXW-1:0]         w_bidx;
  logic                    w_aw_done;
  logic                    w_w_done;

  // First requesting index at or after the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + SW'(i);
      if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
      if (!w_found && i_req_valid[w_sum[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    w_next_ptr = {1'b0, w_gidx} + SW'(1);
    if (w_next_ptr >= SW'(NUM_REQ)) w_next_ptr = '0;
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == IDXW'(i)) begin
        w_sel_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_strb = i_req_strb[i*KEEP_WIDTH +: KEEP_WIDTH];
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && (r_cnt < 8'(MAX_OUTSTANDING)) && w_found;
  assign w_b_hs    = i_m_axi_bvalid && r_bready;
  // A B with nothing outstanding belongs to a write issued before reset: drop it.
  assign w_dec     = w_b_hs && (r_cnt != 8'd0);
  assign w_bidx    = i_m_axi_bid[IDXW-1:0];
  assign w_aw_done = !r_awvalid || i_m_axi_awready;
  assign w_w_done  = !r_wvalid || i_m_axi_wready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_done_valid <= '0;
      r_done_resp  <= '0;
      r_awid       <= '0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      r_bready     <= 1'b1;
      r_done_valid <= '0;
      if (w_dec) begin
        r_done_resp <= i_m_axi_bresp;
        if ({1'b0, w_bidx} < SW'(NUM_REQ)) r_done_valid[w_bidx] <= 1'b1;
      end
      r_cnt <= r_cnt + {7'd0, w_grant} - {7'd0, w_dec};
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_awid    <= ID_WIDTH'(w_gidx);
            r_awaddr  <= {w_sel_addr[ADDR_WIDTH-1:SZ], {SZ{1'b0}}};
            r_wdata   <= w_sel_data;
            r_wstrb   <= w_sel_strb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_rr_ptr  <= w_next_ptr[IDXW-1:0];
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_m_axi_awready) r_awvalid <= 1'b0;
          if (i_m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready     = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
  assign o_done_valid    = r_done_valid;
  assign o_done_resp     = r_done_resp;
  assign o_m_axi_awid    = r_awid;
  assign o_m_axi_awaddr  = r_awaddr;
  assign o_m_axi_awlen   = 8'd0;
  assign o_m_axi_awsize  = 3'(SZ);
  assign o_m_axi_awburst = 2'b01;
  assign o_m_axi_awlock  = 1'b0;
  assign o_m_axi_awcache = 4'd0;
  assign o_m_axi_awprot  = 3'd0;
  assign o_m_axi_awvalid = r_awvalid;
  assign o_m_axi_wdata   = r_wdata;
  assign o_m_axi_wstrb   = r_wstrb;
  assign o_m_axi_wlast   = r_wvalid;
  assign o_m_axi_wvalid  = r_wvalid;
  assign o_m_axi_bready  = r_bready;
  assign o_outstanding   = r_cnt;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Bench for axi_wr_sched: directed scenarios plus a randomized run against a transaction-level model.
module tb_axi_wr_sched;
  localparam int N = 4, DW = 512, KW = 64, AW = 34, IW = 6, MAXO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, done_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*KW-1:0] req_strb;
  logic [1:0]      done_resp;
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [KW-1:0]   wstrb;
  logic            wlast, wvalid, wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [7:0]      outstanding;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_wr_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW),
                 .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_strb(req_strb),
    .o_done_valid(done_valid), .o_done_resp(done_resp),
    .o_m_axi_awid(awid), .o_m_axi_awaddr(awaddr), .o_m_axi_awlen(awlen),
    .o_m_axi_awsize(awsize), .o_m_axi_awburst(awburst), .o_m_axi_awlock(awlock),
    .o_m_axi_awcache(awcache), .o_m_axi_awprot(awprot), .o_m_axi_awvalid(awvalid),
    .i_m_axi_awready(awready),
    .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wlast(wlast),
    .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready),
    .i_m_axi_bid(bid), .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid),
    .o_m_axi_bready(bready), .o_outstanding(outstanding)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    awready   = 1'b1;
    wready    = 1'b1;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = '0;
  endtask

  // Two edges: the reset edge, then one live edge so bready is already up.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'({$urandom(), $urandom()});
      for (int k = 0; k < DW/32; k++) req_data[i*DW + k*32 +: 32] = $urandom();
      req_strb[i*KW +: 32]      = $urandom();
      req_strb[i*KW + 32 +: 32] = $urandom();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rand_payload();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, bready, req_ready, done_valid, done_resp, outstanding} !== '0) begin
      n_err++;
      $display("FAIL reset_state: aw=%b w=%b b=%b rdy=%b done=%b resp=%b out=%0d required all zero",
               awvalid, wvalid, bready, req_ready, done_valid, done_resp, outstanding);
    end
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if (bready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_bready_up: got %b required 1", bready);
    end
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    logic [KW-1:0] s;
    do_reset();
    rand_payload();
    req_addr[0 +: AW] = 34'h1000_0047;
    d = req_data[0 +: DW];
    s = req_strb[0 +: KW];
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL single_grant: got %b required 0001", req_ready);
    end
    step();
    req_valid = '0;
    rand_payload();
    @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, wlast, awid, awaddr} !== {3'b111, 6'd0, 34'h1000_0040}) begin
      n_err++;
      $display("FAIL single_aw: v=%b wv=%b last=%b id=%0d addr=%h required 1 1 1 0 10000040",
               awvalid, wvalid, wlast, awid, awaddr);
    end
    n_cmp++;
    if ({awlen, awsize, awburst, awlock, awcache, awprot} !== {8'd0, 3'd6, 2'b01, 1'b0, 4'd0, 3'd0}) begin
      n_err++;
      $display("FAIL single_const: len=%0d size=%0d burst=%0d lock=%b cache=%0d prot=%0d required 0 6 1 0 0 0",
               awlen, awsize, awburst, awlock, awcache, awprot);
    end
    n_cmp++;
    if (wdata !== d || wstrb !== s) begin
      n_err++;
      $display("FAIL single_wdata: strb=%h required %h (data equal=%b)", wstrb, s, wdata === d);
    end
    n_cmp++;
    if (outstanding !== 8'd1) begin
      n_err++;
      $display("FAIL single_out1: got %0d required 1", outstanding);
    end
    step();
    bvalid = 1'b1; bid = '0; bresp = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop: aw=%b w=%b required 0 0", awvalid, wvalid);
    end
    step();
    bvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done_valid !== 4'b0001 || outstanding !== 8'd0) begin
      n_err++;
      $display("FAIL single_done: done=%b out=%0d required 0001 0", done_valid, outstanding);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    rand_payload();
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp = (c % 2 == 0) ? (4'b0001 << ((c / 2) % N)) : 4'b0000;
      n_cmp++;
      if (req_ready !== exp) begin
        n_err++;
        $display("FAIL rr_order cycle %0d: got %b required %b", c, req_ready, exp);
      end
      step();
    end
  endtask

  task automatic test_split();
    logic [3:0] exp_rdy;
    do_reset();
    rand_payload();
    req_valid = 4'b0001;
    awready = 1'b0;
    wready  = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      awready = (c == 1);
      wready  = (c == 4);
      @(negedge clk);
      exp_rdy = (c == 0 || c == 5) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (req_ready !== exp_rdy || awvalid !== (c == 1) || wvalid !== (c >= 1 && c <= 4)) begin
        n_err++;
        $display("FAIL split cycle %0d: rdy=%b aw=%b w=%b required %b %b %b",
                 c, req_ready, awvalid, wvalid, exp_rdy, c == 1, c >= 1 && c <= 4);
      end
      step();
    end
    req_valid = '0;
    awready = 1'b1;
    wready  = 1'b1;
  endtask

  task automatic test_full();
    int grants;
    do_reset();
    rand_payload();
    req_valid = 4'b1111;
    grants = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (req_ready != 0) grants++;
      step();
    end
    @(negedge clk);
    n_cmp++;
    if (grants !== MAXO || outstanding !== 8'(MAXO) || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL full_block: grants=%0d out=%0d rdy=%b required 8 8 0000", grants, outstanding, req_ready);
    end
    step();
    bvalid = 1'b1; bid = 6'd1;
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready != 0) grants++;
      step();
      bvalid = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (grants !== 1 || outstanding !== 8'(MAXO)) begin
      n_err++;
      $display("FAIL full_one_more: grants=%0d out=%0d required 1 8", grants, outstanding);
    end
    step();
  endtask

  task automatic test_simul();
    int grants;
    do_reset();
    rand_payload();
    req_valid = 4'b1111;
    grants = 0;
    for (int c = 0; c < 20 && grants < 3; c++) begin
      @(negedge clk);
      if (req_ready != 0) grants++;
      step();
    end
    req_valid = '0;
    n_cmp++;
    if (grants !== 3) begin
      n_err++;
      $display("FAIL simul_setup: grants=%0d required 3 within bound", grants);
    end
    step();
    req_valid = 4'b0001;
    bvalid = 1'b1; bid = 6'd2; bresp = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001 || outstanding !== 8'd3) begin
      n_err++;
      $display("FAIL simul_grant: rdy=%b out=%0d required 0001 3", req_ready, outstanding);
    end
    step();
    req_valid = '0;
    bvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outstanding !== 8'd3 || done_valid !== 4'b0100 || done_resp !== 2'b10) begin
      n_err++;
      $display("FAIL simul_result: out=%0d done=%b resp=%b required 3 0100 10", outstanding, done_valid, done_resp);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_payload();
    awready = 1'b0;
    wready  = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL rmid_grant: got %b required 0010", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (awvalid !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_awvalid: got %b required 1", awvalid);
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, bready} !== 3'b000 || outstanding !== 8'd0 || req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_after: aw=%b w=%b b=%b out=%0d rdy=%b required 0 0 0 0 0001",
               awvalid, wvalid, bready, outstanding, req_ready);
    end
    step();
    req_valid = '0;
    awready = 1'b1;
    wready  = 1'b1;
  endtask

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [KW-1:0] strb;
  } txn_t;

  task automatic test_random(input int ncyc);
    int            m_ptr, m_cnt, g, bsel;
    bit            aw_p, w_p, was_busy;
    logic [N-1:0]  exp_rdy, exp_done, nxt_done;
    logic [1:0]    exp_resp, nxt_resp;
    txn_t          cur;
    logic [IW-1:0] q_b[$];
    do_reset();
    m_ptr = 0; m_cnt = 0; aw_p = 0; w_p = 0;
    exp_done = '0; exp_resp = '0; bsel = 0;
    cur = '{default: '0};
    for (int c = 0; c < ncyc; c++) begin
      req_valid = N'($urandom());
      rand_payload();
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      bvalid  = 1'b0;
      if (q_b.size() > 0 && $urandom_range(0, 2) == 0) begin
        bsel   = $urandom_range(0, q_b.size() - 1);
        bvalid = 1'b1;
        bid    = q_b[bsel];
        bresp  = 2'($urandom());
      end
      @(negedge clk);
      n_cmp++;
      if (outstanding !== 8'(m_cnt) || bready !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_count cycle %0d: out=%0d bready=%b required %0d 1", c, outstanding, bready, m_cnt);
      end
      n_cmp++;
      if (done_valid !== exp_done || (exp_done != 0 && done_resp !== exp_resp)) begin
        n_err++;
        $display("FAIL rnd_done cycle %0d: done=%b resp=%b required %b %b", c, done_valid, done_resp, exp_done, exp_resp);
      end
      exp_rdy = '0;
      g = -1;
      if (!aw_p && !w_p && m_cnt < MAXO) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) exp_rdy = N'(1) << g;
      end
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rnd_grant cycle %0d: got %b required %b", c, req_ready, exp_rdy);
      end
      was_busy = aw_p || w_p;
      n_cmp++;
      if (awvalid !== aw_p || (aw_p && (awid !== cur.id || awaddr !== cur.addr))) begin
        n_err++;
        $display("FAIL rnd_aw cycle %0d: v=%b id=%0d addr=%h required %b %0d %h", c, awvalid, awid, awaddr, aw_p, cur.id, cur.addr);
      end
      n_cmp++;
      if (wvalid !== w_p || wlast !== w_p || (w_p && (wdata !== cur.data || wstrb !== cur.strb))) begin
        n_err++;
        $display("FAIL rnd_w cycle %0d: v=%b last=%b strb=%h required %b %b %h", c, wvalid, wlast, wstrb, w_p, w_p, cur.strb);
      end
      if (aw_p && awready) aw_p = 0;
      if (w_p && wready) w_p = 0;
      if (was_busy && !aw_p && !w_p) q_b.push_back(cur.id);
      nxt_done = '0;
      nxt_resp = exp_resp;
      if (bvalid) begin
        if (m_cnt > 0) begin
          m_cnt--;
          nxt_done = N'(1) << bid[1:0];
          nxt_resp = bresp;
        end
        q_b.delete(bsel);
      end
      if (g >= 0) begin
        m_cnt++;
        cur.id   = IW'(g);
        cur.addr = req_addr[g*AW +: AW] & ~34'h3F;
        cur.data = req_data[g*DW +: DW];
        cur.strb = req_strb[g*KW +: KW];
        aw_p = 1; w_p = 1;
        m_ptr = (g + 1) % N;
      end
      exp_done = nxt_done;
      exp_resp = nxt_resp;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    req_addr = '0; req_data = '0; req_strb = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_split();
    test_full();
    test_simul();
    test_reset_mid();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
